// File: rtl/flash_boot_loader.sv
// flash_boot_loader: bus initiator that copies WORDS 32-bit words from a 16-bit flash image into RAM.
// Define BOOT_TIMEOUT_EN to abort a copy when a transfer waits TIMEOUT cycles without ack.
module flash_boot_loader #(
   parameter logic [31:0] FLASH_BASE = 32'h1E00_0000,
   parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
   parameter int          WORDS      = 1024,
   parameter int          TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_data_o,
   input  logic [31:0] bus_data_i,
   output logic        bus_select_o,
   output logic        bus_we_o,
   input  logic        bus_ack_i
);

   localparam int IDXW = $clog2(WORDS) + 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'((WORDS > 32'sd0) ? (WORDS - 32'sd1) : 32'sd0);
   localparam bit EMPTY = (WORDS == 32'sd0);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RD_LO  = 3'd1;
   localparam logic [2:0] GAP_LO = 3'd2;
   localparam logic [2:0] RD_HI  = 3'd3;
   localparam logic [2:0] GAP_HI = 3'd4;
   localparam logic [2:0] WR     = 3'd5;
   localparam logic [2:0] GAP_WR = 3'd6;
   localparam logic [2:0] FIN    = 3'd7;

   logic [2:0]      state;
   logic [IDXW-1:0] idx;
   logic [31:0]     word;
   logic            timeout_hit;
   logic            unused_bits;

   // Byte offset of 32-bit word i; wraps modulo 2^32 when added to a base.
   function automatic logic [31:0] word_offset(input logic [IDXW-1:0] i);
      return 32'({i, 2'b00});
   endfunction

   assign unused_bits = ^bus_data_i[31:16];

`ifdef BOOT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] wait_cnt;

   // Counts select-high cycles of the current transfer; held at zero while select is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!bus_select_o || bus_ack_i) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + TW'(1);
      end
   end

   // An ack arriving on the final allowed cycle still completes the transfer.
   assign timeout_hit = bus_select_o && !bus_ack_i && (wait_cnt == TO_LAST);
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT;
   assign timeout_hit = 1'b0;
`endif

   // Copy sequencer: every bus output is a register so it stays stable across the select window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         word         <= 32'h0000_0000;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         bus_addr_o   <= 32'h0000_0000;
         bus_data_o   <= 32'h0000_0000;
         bus_select_o <= 1'b0;
         bus_we_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  done  <= 1'b0;
                  error <= 1'b0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  if (EMPTY) begin
                     state <= FIN;
                  end else begin
                     state        <= RD_LO;
                     bus_select_o <= 1'b1;
                     bus_we_o     <= 1'b0;
                     bus_addr_o   <= FLASH_BASE;
                  end
               end
            end
            RD_LO, RD_HI, WR: begin
               if (bus_ack_i) begin
                  bus_select_o <= 1'b0;
                  bus_we_o     <= 1'b0;
                  case (state)
                     RD_LO: begin
                        word[15:0] <= bus_data_i[15:0];
                        state      <= GAP_LO;
                     end
                     RD_HI: begin
                        word[31:16] <= bus_data_i[15:0];
                        state       <= GAP_HI;
                     end
                     default: begin
                        state <= GAP_WR;
                     end
                  endcase
               end else if (timeout_hit) begin
                  bus_select_o <= 1'b0;
                  bus_we_o     <= 1'b0;
                  busy         <= 1'b0;
                  error        <= 1'b1;
                  done         <= 1'b0;
                  state        <= IDLE;
               end
            end
            GAP_LO: begin
               state        <= RD_HI;
               bus_select_o <= 1'b1;
               bus_addr_o   <= FLASH_BASE + word_offset(idx) + 32'd2;
            end
            GAP_HI: begin
               state        <= WR;
               bus_select_o <= 1'b1;
               bus_we_o     <= 1'b1;
               bus_addr_o   <= RAM_BASE + word_offset(idx);
               bus_data_o   <= word;
            end
            GAP_WR: begin
               if (idx == LAST_IDX) begin
                  state <= FIN;
               end else begin
                  idx          <= idx + IDXW'(1);
                  state        <= RD_LO;
                  bus_select_o <= 1'b1;
                  bus_addr_o   <= FLASH_BASE + word_offset(idx + IDXW'(1));
               end
            end
            FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state        <= IDLE;
               busy         <= 1'b0;
               bus_select_o <= 1'b0;
               bus_we_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule
